// File: rtl/uart_rcvr_buf.sv
// uart_rcvr_buf: 16x-oversampled UART receiver (2-FF synced rx, start/data/stop FSM) feeding a first-word-fall-through FIFO with frame_err/overrun pulses
module uart_rcvr_buf #(
  parameter int WIDTH = 8,
  parameter int DBIT = 8,
  parameter int SB_TICK = 16,
  parameter int ADDR_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic s_tick,
  input  logic rx,
  input  logic rd_uart,
  output logic [WIDTH-1:0] r_data,
  output logic rx_empty,
  output logic rx_full,
  output logic frame_err,
  output logic overrun
);
  localparam int SW = $clog2(SB_TICK) > 4 ? $clog2(SB_TICK) : 4;
  localparam int NW = DBIT > 1 ? $clog2(DBIT) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [SW-1:0] s, s_n;
  logic [NW-1:0] n, n_n;
  logic [DBIT-1:0] b, b_n;
  logic rx_m, rx_s, done, good, push, pop;
  logic [WIDTH-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk)
    if (reset) begin
      {rx_m, rx_s} <= 2'b11;
      state <= IDLE;
      s <= '0;
      n <= '0;
      b <= '0;
    end else begin
      {rx_m, rx_s} <= {rx, rx_m};
      state <= state_n;
      s <= s_n;
      n <= n_n;
      b <= b_n;
    end
  always_comb begin
    state_n = state;
    s_n = s;
    n_n = n;
    b_n = b;
    done = 1'b0;
    case (state)
      IDLE: if (!rx_s) begin
        state_n = START;
        s_n = '0;
      end
      START: if (s_tick) begin
        s_n = s + SW'(1);
        if (s == SW'(7)) begin
          state_n = rx_s ? IDLE : DATA;
          s_n = '0;
          n_n = '0;
        end
      end
      DATA: if (s_tick) begin
        s_n = s + SW'(1);
        if (s == SW'(15)) begin
          s_n = '0;
          b_n = DBIT'({rx_s, b} >> 1);
          state_n = n == NW'(DBIT - 1) ? STOP : DATA;
          n_n = n + NW'(1);
        end
      end
      STOP: if (s_tick) begin
        s_n = s + SW'(1);
        if (s == SW'(SB_TICK - 1)) begin
          state_n = IDLE;
          done = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  assign good = done & rx_s;
  assign push = good & (!rx_full | rd_uart);
  assign pop = rd_uart & !rx_empty;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= WIDTH'(b);
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rx_empty <= 1'b1;
      rx_full <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + ADDR_W'(push);
      rd_ptr <= rd_ptr + ADDR_W'(pop);
      frame_err <= done & !rx_s;
      overrun <= good & rx_full & !rd_uart;
      if (push != pop) begin
        rx_empty <= pop & (rd_ptr + ADDR_W'(1) == wr_ptr);
        rx_full <= push & (wr_ptr + ADDR_W'(1) == rd_ptr);
      end
    end
  assign r_data = rx_empty ? '0 : mem[rd_ptr];
endmodule

// File: tb/tb_uart_rcvr_buf.sv
// tb_uart_rcvr_buf: table-driven, directed and random frames checked against a queue model of the receive FIFO
module tb_uart_rcvr_buf;
  localparam int W = 8, DB = 8, SBT = 16, AW = 4, DEPTH = 16;
  typedef struct {
    logic [7:0] d;
    logic stop;
    logic exp_fe;
    logic exp_empty;
    logic [7:0] exp_data;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1, s_tick = 1'b0, rx = 1'b1, rd_uart = 1'b0;
  logic [W-1:0] r_data;
  logic rx_empty, rx_full, frame_err, overrun;
  int nchk = 0, nerr = 0, tcnt = 0, fe_seen = 0, ov_seen = 0, fe_exp = 0, ov_exp = 0;
  logic [7:0] q[$];
  vec_t tbl [6];
  uart_rcvr_buf #(.WIDTH(W), .DBIT(DB), .SB_TICK(SBT), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx), .rd_uart(rd_uart),
    .r_data(r_data), .rx_empty(rx_empty), .rx_full(rx_full), .frame_err(frame_err), .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    rd_uart = 1'b0;
    fe_seen += int'(frame_err);
    ov_seen += int'(overrun);
    check("empty_full_both", {31'b0, rx_empty & rx_full}, 0);
    tcnt = (tcnt + 1) % 4;
    s_tick = tcnt == 0;
  endtask
  task automatic tick();
    do cyc(); while (!s_tick);
  endtask
  task automatic check_state(input string tag);
    check({tag, "_empty"}, rx_empty, q.size() == 0);
    check({tag, "_full"}, rx_full, q.size() == DEPTH);
    check({tag, "_rdata"}, r_data, q.size() > 0 ? q[0] : 8'h00);
  endtask
  task automatic pop_check(input string tag);
    check({tag, "_head"}, r_data, q.size() > 0 ? q[0] : 8'h00);
    rd_uart = 1'b1;
    if (q.size() > 0) void'(q.pop_front());
    cyc();
    check_state(tag);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic rd_eval, input int abort_at);
    logic [9:0] bits;
    logic ferr, ovr;
    bits = {stop, d, 1'b0};
    tick();
    for (int k = 0; k < 160; k++) begin
      if (k > 0) tick();
      if (k == abort_at) return;
      rx = (k >= 156 && !stop) ? 1'b1 : bits[k / 16];
      if (k == 152) begin
        check("pre_eval_empty", rx_empty, q.size() == 0);
        rd_uart = rd_eval;
        ferr = !stop;
        ovr = 1'b0;
        if (rd_eval && q.size() > 0) void'(q.pop_front());
        if (stop) begin
          if (q.size() == DEPTH) ovr = 1'b1;
          else q.push_back(d);
        end
        fe_exp += int'(ferr);
        ov_exp += int'(ovr);
        cyc();
        check("eval_frame_err", frame_err, ferr);
        check("eval_overrun", overrun, ovr);
        check_state("eval");
      end
    end
  endtask
  initial begin
    tbl = '{
      '{8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5},
      '{8'h3C, 1'b0, 1'b1, 1'b1, 8'h00},
      '{8'h81, 1'b1, 1'b0, 1'b0, 8'h81},
      '{8'h00, 1'b1, 1'b0, 1'b0, 8'h00},
      '{8'hFF, 1'b1, 1'b0, 1'b0, 8'hFF},
      '{8'h5A, 1'b0, 1'b1, 1'b1, 8'h00}
    };
    repeat (3) cyc();
    check_state("reset");
    check("reset_fe", frame_err, 0);
    check("reset_ov", overrun, 0);
    reset = 1'b0;
    repeat (2000) cyc();
    check_state("idle");
    check("idle_fe_cnt", fe_seen, 0);
    check("idle_ov_cnt", ov_seen, 0);
    for (int i = 0; i < 6; i++) begin
      int fe0;
      fe0 = fe_seen;
      send_frame(tbl[i].d, tbl[i].stop, 1'b0, -1);
      check("tbl_empty", rx_empty, tbl[i].exp_empty);
      check("tbl_rdata", r_data, tbl[i].exp_data);
      check("tbl_fe_pulses", fe_seen - fe0, tbl[i].exp_fe);
      if (!tbl[i].exp_empty) begin
        pop_check("tbl_pop");
        check("tbl_after_pop_empty", rx_empty, 1);
      end
    end
    tick();
    rx = 1'b0;
    repeat (5) tick();
    rx = 1'b1;
    repeat (20) tick();
    check_state("glitch");
    check("glitch_fe", fe_seen, fe_exp);
    check("glitch_ov", ov_seen, ov_exp);
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 1'b1, 1'b0, -1);
      if (i == 15) check("full_after_16", rx_full, 1);
    end
    check("ovr_once", ov_seen, 1);
    for (int i = 0; i < 16; i++) begin
      check("drain_order", r_data, i);
      pop_check("drain");
    end
    for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 1'b1, 1'b0, -1);
    send_frame(8'h55, 1'b1, 1'b1, -1);
    check("full_rd_push_full", rx_full, 1);
    check("full_rd_no_ovr", ov_seen, 1);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("last_is_55", r_data, 8'h55);
      pop_check("drain2");
    end
    for (int i = 0; i < 3; i++) send_frame(8'h90 + 8'(i), 1'b1, 1'b0, -1);
    send_frame(8'hC3, 1'b1, 1'b0, 60);
    reset = 1'b1;
    rx = 1'b1;
    q.delete();
    repeat (2) cyc();
    check_state("midreset");
    check("midreset_fe", frame_err, 0);
    check("midreset_ov", overrun, 0);
    reset = 1'b0;
    repeat (200) cyc();
    check_state("post_reset_idle");
    send_frame(8'h7E, 1'b1, 1'b0, -1);
    check("after_reset_7e", r_data, 8'h7E);
    pop_check("after_reset_pop");
    for (int i = 0; i < 30; i++) begin
      send_frame(8'($urandom), $urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0, -1);
      repeat ($urandom_range(0, 2)) pop_check("rnd_pop");
      repeat ($urandom_range(0, 2)) tick();
    end
    repeat (40) tick();
    check("total_fe", fe_seen, fe_exp);
    check("total_ov", ov_seen, ov_exp);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
